// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-mode clock divider: board clock rate and
// the half-period counts of the standard display rates.
package clk_div_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Half-period in board-clock cycles for a square wave of the given rate.
  function automatic int unsigned half_for_hz(input int unsigned hz);
    return (hz == 0) ? 0 : CLK_HZ / (2 * hz);
  endfunction

  localparam int unsigned HALF_1HZ  = half_for_hz(1);
  localparam int unsigned HALF_2HZ  = half_for_hz(2);
  localparam int unsigned HALF_5HZ  = half_for_hz(5);
  localparam int unsigned HALF_10HZ = half_for_hz(10);

endpackage

// File: rtl/clk_div_sync.sv
// Generic two-flop synchronizer for slow multi-bit board inputs such as
// switch banks; both stages clear to zero on reset.
module clk_div_sync #(
  parameter int W = 2
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-mode square-wave divider with glitch-free mode switching at half-period
// boundaries. Define CLK_DIV_SYNC_EN to pass Mode through a 2-flop synchronizer.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int          NUM_MODES = 4,
  parameter  int          CNT_W     = 32,
  parameter  int unsigned HALF0     = HALF_1HZ,
  parameter  int unsigned HALF1     = HALF_2HZ,
  parameter  int unsigned HALF2     = HALF_5HZ,
  parameter  int unsigned HALF3     = HALF_10HZ,
  parameter  int unsigned HALF4     = HALF_10HZ,
  parameter  int unsigned HALF5     = HALF_10HZ,
  parameter  int unsigned HALF6     = HALF_10HZ,
  parameter  int unsigned HALF7     = HALF_10HZ,
  localparam int          MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic [MODE_W-1:0] Mode,
  output logic              Clk_O,
  output logic              Tick,
  output logic [MODE_W-1:0] Mode_Act,
  output logic              Sw_Pend
);

  localparam logic [MODE_W:0] MODE_LIM = (MODE_W + 1)'(NUM_MODES);

  function automatic logic [CNT_W-1:0] half_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return CNT_W'(HALF0);
      3'd1:    return CNT_W'(HALF1);
      3'd2:    return CNT_W'(HALF2);
      3'd3:    return CNT_W'(HALF3);
      3'd4:    return CNT_W'(HALF4);
      3'd5:    return CNT_W'(HALF5);
      3'd6:    return CNT_W'(HALF6);
      default: return CNT_W'(HALF7);
    endcase
  endfunction

  logic [MODE_W-1:0] mode_in;
  logic [MODE_W-1:0] mode_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  last;
  logic              terminal;
  logic              overrun;

`ifdef CLK_DIV_SYNC_EN
  clk_div_sync #(.W(MODE_W)) u_sync (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .d     (Mode),
    .q     (mode_in)
  );
`else
  assign mode_in = Mode;
`endif

  // Out-of-range requests are dropped so Mode_Act can never index a missing divisor.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      mode_q <= '0;
    else if ({1'b0, mode_in} < MODE_LIM)
      mode_q <= mode_in;
  end

  assign last     = half_of(3'(Mode_Act)) - CNT_W'(1);
  assign terminal = (count == last);
  assign overrun  = (count > last);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count    <= '0;
      Clk_O    <= 1'b0;
      Tick     <= 1'b0;
      Mode_Act <= '0;
      Sw_Pend  <= 1'b0;
    end else begin
      Sw_Pend <= (mode_q != Mode_Act);
      if (!En) begin
        // Stopped: nothing to protect, so the requested mode takes effect at once.
        count    <= '0;
        Clk_O    <= 1'b0;
        Tick     <= 1'b0;
        Mode_Act <= mode_q;
      end else if (terminal) begin
        count    <= '0;
        Clk_O    <= ~Clk_O;
        Tick     <= ~Clk_O;
        Mode_Act <= mode_q;
      end else if (overrun) begin
        count <= '0;
        Tick  <= 1'b0;
      end else begin
        count <= count + CNT_W'(1);
        Tick  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with HALF = {2,3,5,1}; timing expectations
// follow the build (CLK_DIV_SYNC_EN adds two cycles of Mode latency).
module tb_clk_div_multi;

`ifdef CLK_DIV_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  // Cycles from applying Mode=2 just after a rise in mode 0 to Mode_Act=2.
  localparam int SW_N   = (LAT == 1) ? 2 : 4;
  localparam int BUDGET = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       clk_o;
  logic       tick;
  logic [1:0] mode_act;
  logic       sw_pend;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_MODES (4),
    .CNT_W     (32),
    .HALF0     (2),
    .HALF1     (3),
    .HALF2     (5),
    .HALF3     (1)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .En       (en),
    .Mode     (mode),
    .Clk_O    (clk_o),
    .Tick     (tick),
    .Mode_Act (mode_act),
    .Sw_Pend  (sw_pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_tick(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick && n <= BUDGET);
  endtask

  task automatic phase_len(output int n);
    logic lvl;
    lvl = clk_o;
    n = 0;
    do begin
      step(1);
      n++;
    end while (clk_o == lvl && n <= BUDGET);
  endtask

  task automatic to_mode_act(input logic [1:0] m, output int n);
    n = 0;
    while (mode_act !== m && n <= BUDGET) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int   n;
    logic prev;
    int   toggles;
    logic seen_pend;
    logic bad;

    // Scenario 1: reset values, then mode 0 at period 4.
    #1 rst_n = 1'b0;
    step(2);
    check("rst_clk_o", clk_o, 0);
    check("rst_tick", tick, 0);
    check("rst_mode_act", mode_act, 0);
    check("rst_sw_pend", sw_pend, 0);
    #3 rst_n = 1'b1;
    step(1);
    check("m0_first_low", clk_o, 0);
    step(1);
    check("m0_first_rise", clk_o, 1);
    check("m0_first_tick", tick, 1);
    to_tick(n);
    check("m0_period_a", n, 4);
    to_tick(n);
    check("m0_period_b", n, 4);
    phase_len(n);
    check("m0_high", n, 2);
    phase_len(n);
    check("m0_low", n, 2);

    // Scenario 2: request mode 2 just after a rise; switch waits for the boundary.
    mode = 2'd2;
    to_mode_act(2'd2, n);
    check("sw2_delay", n, SW_N);
    check("sw2_pend_at_switch", sw_pend, 1);
    phase_len(n);
    check("m2_phase_a", n, 5);
    check("sw2_pend_cleared", sw_pend, 0);
    phase_len(n);
    check("m2_phase_b", n, 5);
    to_tick(n);
    to_tick(n);
    check("m2_period", n, 10);

    // Scenario 3: back to mode 0, then a one-cycle 3 that must be cancelled.
    mode = 2'd0;
    to_mode_act(2'd0, n);
    check("back_to_m0", mode_act, 0);
    to_tick(n);
    step(1);
    mode = 2'd3;
    step(1);
    check("cancel_fall", clk_o, 0);
    mode = 2'd0;
    seen_pend = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen_pend |= sw_pend;
      bad |= (mode_act != 2'd0);
    end
    check("cancel_pend_seen", seen_pend, 1);
    check("cancel_no_switch", bad, 0);
    check("cancel_pend_end", sw_pend, 0);
    to_tick(n);
    to_tick(n);
    check("cancel_period", n, 4);

    // Scenario 4: mode 3 (HALF=1), stop/restart, mode load while stopped.
    mode = 2'd3;
    to_mode_act(2'd3, n);
    check("m3_reached", mode_act, 3);
    toggles = 0;
    for (int i = 0; i < 4; i++) begin
      prev = clk_o;
      step(1);
      if (clk_o != prev) toggles++;
    end
    check("m3_toggles", toggles, 4);
    to_tick(n);
    to_tick(n);
    check("m3_period", n, 2);
    en = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      bad |= clk_o | tick;
    end
    check("stop_quiet", bad, 0);
    en = 1'b1;
    step(1);
    check("restart_rise", clk_o, 1);
    check("restart_tick", tick, 1);
    en = 1'b0;
    mode = 2'd1;
    step(LAT + 1);
    check("stop_load_mode", mode_act, 1);
    check("stop_load_pend", sw_pend, 1);
    step(1);
    check("stop_pend_clear", sw_pend, 0);

    // Scenario 5: asynchronous reset while Clk_O is high in mode 1.
    en = 1'b1;
    step(3);
    check("m1_first_rise", clk_o, 1);
    check("m1_first_tick", tick, 1);
    to_tick(n);
    check("m1_period", n, 6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk_o", clk_o, 0);
    check("arst_tick", tick, 0);
    check("arst_mode_act", mode_act, 0);
    check("arst_sw_pend", sw_pend, 0);
    mode = 2'd0;
    step(1);
    check("arst_hold", clk_o, 0);
    #3 rst_n = 1'b1;
    step(1);
    check("rel_low", clk_o, 0);
    step(1);
    check("rel_rise", clk_o, 1);
    check("rel_tick", tick, 1);
    to_tick(n);
    check("rel_period", n, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
